// File: rtl/hub_partition_if.sv
// hub_partition_if: nibble-rate control bus between the elastic buffers,
// the hub core and the auto-partition controller.
interface hub_partition_if #(
    parameter int PORT_COUNT = 4
);
    logic                  ce;
    logic [PORT_COUNT-1:0] activity;
    logic                  collision;
    logic [PORT_COUNT-1:0] clear;
    logic [PORT_COUNT-1:0] partitioned;
    logic [PORT_COUNT-1:0] partition_event;

    modport master (
        output ce, activity, collision, clear,
        input  partitioned, partition_event
    );

    modport slave (
        input  ce, activity, collision, clear,
        output partitioned, partition_event
    );
endinterface

// File: rtl/hub_partition.sv
// hub_partition: per-port auto-partition controller for the repeater hub.
// Isolates a port after CC_LIMIT consecutive colliding packets (and, when
// HUB_LONG_COLLISION_EN is defined, after LONG_COL_NIBBLES consecutive
// collision nibbles), reconnects it after a clean packet of at least
// RECONNECT_NIBBLES nibbles. Build macro: HUB_LONG_COLLISION_EN.

module hub_partition_port #(
    parameter int CC_LIMIT          = 60,
    parameter int LONG_COL_NIBBLES  = 144,
    parameter int RECONNECT_NIBBLES = 128
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ce,
    input  logic i_act,
    input  logic i_col,
    input  logic i_clear,
    output logic o_part,
    output logic o_event
);
    localparam int CW = $clog2(CC_LIMIT + 1);
    localparam logic [CW:0] CC_LIM = (CW + 1)'(CC_LIMIT);
    localparam logic [9:0]  RC_LIM = 10'(RECONNECT_NIBBLES);
    localparam logic [9:0]  SAT    = 10'd1023;

    if (CC_LIMIT < 2 || CC_LIMIT > 1023) begin : g_bad_cc
        $error("hub_partition: CC_LIMIT out of range 2..1023");
    end
    if (LONG_COL_NIBBLES < 2 || LONG_COL_NIBBLES > 1023) begin : g_bad_lc
        $error("hub_partition: LONG_COL_NIBBLES out of range 2..1023");
    end
    if (RECONNECT_NIBBLES < 1 || RECONNECT_NIBBLES > 1023) begin : g_bad_rc
        $error("hub_partition: RECONNECT_NIBBLES out of range 1..1023");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, WATCH = 2'd1, PART = 2'd2, PWATCH = 2'd3} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_prev, r_armed;
    logic          r_hit, w_hit_nxt;
    logic [CW-1:0] r_cc, w_cc_nxt;
    logic [CW:0]   w_cc_inc;
    logic [9:0]    r_len, w_len_nxt, w_len_inc;
    logic          w_nib, w_sop, w_eop, w_coln;
    logic          w_part_nxt, w_event_nxt;
`ifdef HUB_LONG_COLLISION_EN
    localparam logic [9:0] LC_LIM = 10'(LONG_COL_NIBBLES);
    logic [9:0] r_lc, w_lc_nxt, w_lc_inc;
    assign w_lc_inc = (r_lc == SAT) ? r_lc : r_lc + 10'd1;
`endif

    // r_armed blocks a packet already in flight at reset release from
    // looking like a start: activity must first be sampled low.
    assign w_nib     = i_ce & i_act;
    assign w_sop     = w_nib & ~r_prev & r_armed;
    assign w_eop     = i_ce & ~i_act & r_prev;
    assign w_coln    = w_nib & i_col;
    assign w_cc_inc  = {1'b0, r_cc} + {{CW{1'b0}}, 1'b1};
    assign w_len_inc = (r_len == SAT) ? r_len : r_len + 10'd1;

    // State and per-port counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_hit   <= 1'b0;
            r_cc    <= '0;
            r_len   <= '0;
`ifdef HUB_LONG_COLLISION_EN
            r_lc    <= '0;
`endif
            o_part  <= 1'b0;
            o_event <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hit   <= w_hit_nxt;
            r_cc    <= w_cc_nxt;
            r_len   <= w_len_nxt;
`ifdef HUB_LONG_COLLISION_EN
            r_lc    <= w_lc_nxt;
`endif
            if (i_ce) begin
                r_prev <= i_act;
                if (!i_act) r_armed <= 1'b1;
            end
            o_part  <= w_part_nxt;
            o_event <= w_event_nxt;
        end
    end

    // Next state and counter updates; clear overrides everything.
    // The start nibble is the packet's first nibble, so it is counted in
    // len and, if it collides, in hit/lc.
    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit;
        w_cc_nxt    = r_cc;
        w_len_nxt   = r_len;
`ifdef HUB_LONG_COLLISION_EN
        w_lc_nxt    = r_lc;
`endif
        case (r_state)
            IDLE: begin
                if (w_sop) begin
                    w_state_nxt = WATCH;
                    w_len_nxt   = 10'd1;
                    w_hit_nxt   = i_col;
`ifdef HUB_LONG_COLLISION_EN
                    w_lc_nxt    = {9'd0, i_col};
`endif
                end
            end
            WATCH: begin
                if (w_coln) begin
                    w_hit_nxt = 1'b1;
`ifdef HUB_LONG_COLLISION_EN
                    w_lc_nxt  = w_lc_inc;
                    if (w_lc_inc >= LC_LIM) begin
                        w_state_nxt = PART;
                        w_cc_nxt    = '0;
                    end
`endif
                end else if (w_nib) begin
`ifdef HUB_LONG_COLLISION_EN
                    w_lc_nxt = '0;
`endif
                end
                if (w_nib) w_len_nxt = w_len_inc;
                if (w_eop) begin
                    if (r_hit) begin
                        if (w_cc_inc >= CC_LIM) begin
                            w_state_nxt = PART;
                            w_cc_nxt    = '0;
                        end else begin
                            w_state_nxt = IDLE;
                            w_cc_nxt    = w_cc_inc[CW-1:0];
                        end
                    end else begin
                        w_state_nxt = IDLE;
                        w_cc_nxt    = '0;
                    end
                end
            end
            PART: begin
                // A start nibble that already collides disqualifies the packet.
                if (w_sop && !i_col) begin
                    w_state_nxt = PWATCH;
                    w_len_nxt   = 10'd1;
                end
            end
            PWATCH: begin
                if (w_coln) begin
                    w_state_nxt = PART;
                end else if (w_nib) begin
                    w_len_nxt = w_len_inc;
                end else if (w_eop) begin
                    if (r_len >= RC_LIM) begin
                        w_state_nxt = IDLE;
                        w_cc_nxt    = '0;
                    end else begin
                        w_state_nxt = PART;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_clear) begin
            w_state_nxt = IDLE;
            w_hit_nxt   = 1'b0;
            w_cc_nxt    = '0;
            w_len_nxt   = '0;
`ifdef HUB_LONG_COLLISION_EN
            w_lc_nxt    = '0;
`endif
        end
    end

    // Outputs derived from the transition being taken this clk
    always_comb begin
        w_part_nxt  = (w_state_nxt == PART) || (w_state_nxt == PWATCH);
        w_event_nxt = (r_state == WATCH) && (w_state_nxt == PART);
    end
endmodule

module hub_partition #(
    parameter int PORT_COUNT        = 4,
    parameter int CC_LIMIT          = 60,
    parameter int LONG_COL_NIBBLES  = 144,
    parameter int RECONNECT_NIBBLES = 128
) (
    input  logic            clk,
    input  logic            rst,
    hub_partition_if.slave  hub
);
    logic [PORT_COUNT-1:0] w_part;
    logic [PORT_COUNT-1:0] w_event;

    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
        hub_partition_port #(
            .CC_LIMIT          (CC_LIMIT),
            .LONG_COL_NIBBLES  (LONG_COL_NIBBLES),
            .RECONNECT_NIBBLES (RECONNECT_NIBBLES)
        ) u_port (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_ce    (hub.ce),
            .i_act   (hub.activity[g]),
            .i_col   (hub.collision),
            .i_clear (hub.clear[g]),
            .o_part  (w_part[g]),
            .o_event (w_event[g])
        );
    end

    assign hub.partitioned     = w_part;
    assign hub.partition_event = w_event;
endmodule
